uart_echo_core: RTL and testbench

Parametrised byte-processing buffer between the UART receiver's write interface (dout/we) and the transmitter's read interface (din/empty/re). It is the next generation of the fixed input-FIFO, process and output-FIFO chain, collapsed into one block. It has an internal FIFO of configurable depth and width, a runtime-selectable transform/release mode, overflow accounting and activity/error LED drive. It sits in the loopback top and replaces the two fifo_buffer instances and the process block.

---
 rtl/uart_echo_core.sv | 118 +++++++++++
 tb/tb_uart_echo_core.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_core.sv
// Byte buffer between UART RX and TX: circular FIFO with optional uppercase
// transform, line-buffered release, overflow accounting and LED drive.
module uart_echo_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 16,
  parameter int ACT_HOLD   = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_we,
  output logic                  rx_full,
  input  logic [1:0]            mode,
  output logic [DATA_WIDTH-1:0] tx_din,
  output logic                  tx_empty,
  input  logic                  tx_re,
  output logic [CNT_W-1:0]      overflow_count,
  output logic                  led_activity,
  output logic                  led_error
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ACT_W = (ACT_HOLD > 1) ? $clog2(ACT_HOLD) : 1;

  localparam logic [AW:0]           FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] LC_A     = DATA_WIDTH'('h61);
  localparam logic [DATA_WIDTH-1:0] LC_Z     = DATA_WIDTH'('h7A);
  localparam logic [DATA_WIDTH-1:0] CASE_OFS = DATA_WIDTH'('h20);
  localparam logic [DATA_WIDTH-1:0] CH_LF    = DATA_WIDTH'('h0A);
  localparam logic [DATA_WIDTH-1:0] CH_CR    = DATA_WIDTH'('h0D);
  localparam logic [ACT_W-1:0]      ACT_LOAD = ACT_W'(ACT_HOLD - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [AW:0]           r_rel_cnt;
  logic                  r_tx_empty;
  logic [CNT_W-1:0]      r_ovf_cnt;
  logic                  r_led_err;
  logic [ACT_W-1:0]      r_act_cnt;
  logic                  r_led_act;

  logic                  w_full;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_is_term;
  logic                  w_commit;
  logic [AW:0]           w_count_nxt;
  logic [AW:0]           w_rel_nxt;
  logic [DATA_WIDTH-1:0] w_wdata;

  // Handshake: a word is accepted on rx_we when not full; a word is consumed
  // on tx_re when tx_empty is low. Requests outside those conditions are no-ops
  // (a write while full is counted as an overflow).
  assign w_full = (r_count == FULL_CNT);
  assign w_push = rx_we & ~w_full;
  assign w_drop = rx_we & w_full;
  assign w_pop  = tx_re & ~r_tx_empty;

  always_comb begin
    w_wdata = rx_data;
    if ((DATA_WIDTH == 8) && (mode == 2'd1) && (rx_data >= LC_A) && (rx_data <= LC_Z))
      w_wdata = rx_data - CASE_OFS;
  end

  assign w_is_term   = (rx_data == CH_LF) || (rx_data == CH_CR);
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  // Outside mode 2 everything stored is releasable; in mode 2 a line end or a
  // push that fills the buffer releases everything written so far.
  assign w_commit  = (mode != 2'd2) || (w_push && (w_is_term || (w_count_nxt == FULL_CNT)));
  assign w_rel_nxt = w_commit ? w_count_nxt : (r_rel_cnt - (AW+1)'(w_pop));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rel_cnt  <= '0;
      r_tx_empty <= 1'b1;
      r_ovf_cnt  <= '0;
      r_led_err  <= 1'b0;
      r_act_cnt  <= '0;
      r_led_act  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_nxt;
      r_rel_cnt  <= w_rel_nxt;
      r_tx_empty <= (w_rel_nxt == '0);
      if (w_drop && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      if (w_drop) r_led_err <= 1'b1;
      if (w_pop) begin
        r_act_cnt <= ACT_LOAD;
        r_led_act <= 1'b1;
      end else if (r_act_cnt != '0) begin
        r_act_cnt <= r_act_cnt - 1'b1;
      end else begin
        r_led_act <= 1'b0;
      end
    end
  end

  assign rx_full        = w_full;
  assign tx_din         = r_mem[r_rd_ptr];
  assign tx_empty       = r_tx_empty;
  assign overflow_count = r_ovf_cnt;
  assign led_activity   = r_led_act;
  assign led_error      = r_led_err;

endmodule

// File: tb/tb_uart_echo_core.sv
// Directed bench for uart_echo_core: echo, uppercase, line mode, overflow,
// force-commit, reset and activity LED hold time.
module tb_uart_echo_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_we;
  logic        rx_full;
  logic [1:0]  mode;
  logic [7:0]  tx_din;
  logic        tx_empty;
  logic        tx_re;
  logic [15:0] overflow_count;
  logic        led_activity;
  logic        led_error;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  uart_echo_core #(
    .DATA_WIDTH(8), .DEPTH(16), .CNT_W(16), .ACT_HOLD(4)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_we(rx_we), .rx_full(rx_full),
    .mode(mode), .tx_din(tx_din), .tx_empty(tx_empty), .tx_re(tx_re),
    .overflow_count(overflow_count), .led_activity(led_activity), .led_error(led_error)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] d);
    rx_data = d;
    rx_we   = 1'b1;
    step();
    rx_we   = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_empty"}, 32'(tx_empty), 32'd0);
    check(tag, 32'(tx_din), 32'(exp));
    tx_re = 1'b1;
    step();
    tx_re = 1'b0;
  endtask

  task automatic pop_from_q(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      pop_expect(tag, e);
    end
  endtask

  logic [7:0] echo_v [3]  = '{8'h41, 8'h62, 8'h0A};
  logic [7:0] up_in  [4]  = '{8'h61, 8'h7A, 8'h7B, 8'h40};
  logic [7:0] up_exp [4]  = '{8'h41, 8'h5A, 8'h7B, 8'h40};

  initial begin
    int any_ne;
    int hi_cnt;
    rst = 1'b1; rx_data = '0; rx_we = 1'b0; mode = 2'd0; tx_re = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_full",  32'(rx_full), 32'd0);
    check("rst_empty", 32'(tx_empty), 32'd1);
    check("rst_act",   32'(led_activity), 32'd0);
    check("rst_err",   32'(led_error), 32'd0);
    check("rst_ovf",   32'(overflow_count), 32'd0);

    // Raw echo with tx_re held: each word visible right after its push.
    mode = 2'd0;
    tx_re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = echo_v[i];
      rx_we = 1'b1;
      step();
      check("echo_empty", 32'(tx_empty), 32'd0);
      check("echo_din", 32'(tx_din), 32'(echo_v[i]));
    end
    rx_we = 1'b0;
    step();
    check("echo_drain", 32'(tx_empty), 32'd1);
    check("echo_act", 32'(led_activity), 32'd1);
    step();
    tx_re = 1'b0;
    check("pop_on_empty", 32'(tx_empty), 32'd1);

    // Uppercase transform
    mode = 2'd1;
    for (int i = 0; i < 4; i++) push(up_in[i]);
    for (int i = 0; i < 4; i++) pop_expect("upper", up_exp[i]);
    check("upper_drain", 32'(tx_empty), 32'd1);

    // Line-buffered release
    mode = 2'd2;
    push(8'h68);
    push(8'h69);
    any_ne = 0;
    for (int i = 0; i < 100; i++) begin
      if (!tx_empty) any_ne++;
      step();
    end
    check("line_hold", 32'(any_ne), 32'd0);
    push(8'h0D);
    check("line_commit", 32'(tx_empty), 32'd0);
    pop_expect("line", 8'h68);
    pop_expect("line", 8'h69);
    pop_expect("line", 8'h0D);
    check("line_drain", 32'(tx_empty), 32'd1);

    // Overflow with tx_re idle
    mode = 2'd0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) exp_q.push_back(8'(8'h10 + i));
      push(8'(8'h10 + i));
      if (i == 14) check("not_full_15", 32'(rx_full), 32'd0);
      if (i == 15) check("full_16", 32'(rx_full), 32'd1);
    end
    check("ovf_cnt4", 32'(overflow_count), 32'd4);
    check("ovf_err", 32'(led_error), 32'd1);
    for (int i = 0; i < 16; i++) pop_from_q("ovf_pop");
    check("ovf_drain", 32'(tx_empty), 32'd1);
    check("ovf_unfull", 32'(rx_full), 32'd0);

    // Overflow coinciding with a pop: the write is still dropped
    for (int i = 0; i < 16; i++) begin
      if (i > 0) exp_q.push_back(8'(8'h30 + i));
      push(8'(8'h30 + i));
    end
    rx_data = 8'hEE; rx_we = 1'b1; tx_re = 1'b1;
    step();
    rx_we = 1'b0; tx_re = 1'b0;
    check("ovf_cnt5", 32'(overflow_count), 32'd5);
    check("ovf_pop_full", 32'(rx_full), 32'd0);
    for (int i = 0; i < 15; i++) pop_from_q("ovf2_pop");
    check("ovf2_drain", 32'(tx_empty), 32'd1);

    // Mode 2 force-commit on filling the buffer
    mode = 2'd2;
    for (int i = 0; i < 16; i++) begin
      push(8'(8'h41 + i));
      if (i == 14) check("fc_hold15", 32'(tx_empty), 32'd1);
      if (i == 15) check("fc_commit16", 32'(tx_empty), 32'd0);
    end
    for (int i = 0; i < 16; i++) pop_expect("fc_pop", 8'(8'h41 + i));

    // Leaving mode 2 releases pending words
    push(8'h50); push(8'h51); push(8'h52);
    check("leave_hold", 32'(tx_empty), 32'd1);
    mode = 2'd0;
    step();
    check("leave_commit", 32'(tx_empty), 32'd0);
    pop_expect("leave_pop", 8'h50);
    pop_expect("leave_pop", 8'h51);
    pop_expect("leave_pop", 8'h52);

    // Reset mid-stream with activity LED lit
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
    pop_expect("pre_rst", 8'h60);
    check("pre_rst_act", 32'(led_activity), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_empty", 32'(tx_empty), 32'd1);
    check("mid_rst_ovf", 32'(overflow_count), 32'd0);
    check("mid_rst_act", 32'(led_activity), 32'd0);
    check("mid_rst_err", 32'(led_error), 32'd0);
    check("mid_rst_full", 32'(rx_full), 32'd0);

    // Activity hold time: ACT_HOLD=4 cycles per pop
    push(8'h77);
    check("act_idle", 32'(led_activity), 32'd0);
    tx_re = 1'b1;
    step();
    tx_re = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (led_activity) hi_cnt++;
      step();
    end
    check("act_hold", 32'(hi_cnt), 32'd4);
    check("act_off", 32'(led_activity), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
